// File: rtl/cpu_pkg.sv
// Shared pipeline types for the operand-fetch slice: result latency classes and
// the per-stage hazard tracker slot.
package cpu_pkg;

   localparam int unsigned CPU_REG_W = 5;

   typedef enum logic [1:0] {
      LAT_ALU  = 2'd0,
      LAT_LOAD = 2'd1,
      LAT_NONE = 2'd2
   } lat_e;

   typedef struct packed {
      logic                 v;
      logic [CPU_REG_W-1:0] rg;
      lat_e                 lat;
   } trk_slot_t;

   function automatic logic slot_hit(input trk_slot_t s, input logic [CPU_REG_W-1:0] src);
      return s.v && (s.rg == src);
   endfunction

endpackage

// File: rtl/bypass_mux.sv
// Per-source operand resolution: picks E/M/W bypass or register file data and
// requests a stall when the youngest in-flight writer cannot yet supply the value.
module bypass_mux
   import cpu_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_W  = CPU_REG_W,
   parameter bit          FWD_EN = 1'b1
) (
   input  logic [REG_W-1:0]  src_i,
   input  logic              use_i,
   input  trk_slot_t         t_e_i,
   input  trk_slot_t         t_m_i,
   input  trk_slot_t         t_w_i,
   input  logic [DATA_W-1:0] rf_data_i,
   input  logic [DATA_W-1:0] e_data_i,
   input  logic [DATA_W-1:0] m_data_i,
   input  logic [DATA_W-1:0] w_data_i,
   output logic [DATA_W-1:0] value_o,
   output logic              stall_req_o
);

   logic [CPU_REG_W-1:0] src_c;
   logic                 src_nz;
   logic                 hit_e;
   logic                 hit_m;
   logic                 hit_w;

   assign src_c  = CPU_REG_W'(src_i);
   assign src_nz = (src_i != '0);
   assign hit_e  = src_nz && use_i && slot_hit(t_e_i, src_c);
   assign hit_m  = src_nz && use_i && slot_hit(t_m_i, src_c);
   assign hit_w  = src_nz && use_i && slot_hit(t_w_i, src_c);

   // Priority is youngest first; a W match always bypasses because the
   // register file write only lands at the coming edge.
   always_comb begin
      value_o     = rf_data_i;
      stall_req_o = 1'b0;
      if (!src_nz) begin
         value_o = '0;
      end else if (hit_e) begin
         if (FWD_EN && (t_e_i.lat == LAT_ALU)) value_o = e_data_i;
         else                                  stall_req_o = 1'b1;
      end else if (hit_m) begin
         if (FWD_EN && (t_m_i.lat == LAT_ALU)) value_o = m_data_i;
         else                                  stall_req_o = 1'b1;
      end else if (hit_w) begin
         value_o = w_data_i;
      end
   end

endmodule

// File: rtl/operand_fetch.sv
// Decode-to-execute operand fetch: register file read addressing, RAW hazard
// tracking over E/M/W, bypass/stall resolution and the D->E operand register.
module operand_fetch
   import cpu_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_W  = CPU_REG_W,
   parameter bit          FWD_EN = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              d_valid,
   input  logic [REG_W-1:0]  d_rs,
   input  logic [REG_W-1:0]  d_rt,
   input  logic              d_use_rs,
   input  logic              d_use_rt,
   input  logic              d_we,
   input  logic [REG_W-1:0]  d_rd,
   input  logic [1:0]        d_lat,
   output logic              d_ready,
   output logic [REG_W-1:0]  a1,
   output logic [REG_W-1:0]  a2,
   input  logic [DATA_W-1:0] rd1,
   input  logic [DATA_W-1:0] rd2,
   input  logic [DATA_W-1:0] e_fwd_data,
   input  logic [DATA_W-1:0] m_fwd_data,
   input  logic              w_we,
   input  logic [REG_W-1:0]  w_a3,
   input  logic [DATA_W-1:0] w_wd,
   input  logic              flush,
   output logic              op_valid,
   output logic [DATA_W-1:0] op_a,
   output logic [DATA_W-1:0] op_b,
   output logic              op_we,
   output logic [REG_W-1:0]  op_rd,
   output logic [1:0]        op_lat
);

   trk_slot_t         t_e_q, t_m_q, t_w_q, t_e_d;
   logic              op_valid_q;
   logic [DATA_W-1:0] op_a_q, op_b_q;
   logic              op_we_q;
   logic [REG_W-1:0]  op_rd_q;
   logic [1:0]        op_lat_q;

   logic [DATA_W-1:0] val_a, val_b;
   logic              stall_a, stall_b, stall;
   logic              issue, load;

   // The W bypass is keyed on the tracker; the write port is observed only by the register file.
   logic unused_w;
   assign unused_w = ^{w_we, w_a3};

   assign a1 = d_rs;
   assign a2 = d_rt;

   bypass_mux #(.DATA_W(DATA_W), .REG_W(REG_W), .FWD_EN(FWD_EN)) u_mux_a (
      .src_i      (d_rs),
      .use_i      (d_use_rs),
      .t_e_i      (t_e_q),
      .t_m_i      (t_m_q),
      .t_w_i      (t_w_q),
      .rf_data_i  (rd1),
      .e_data_i   (e_fwd_data),
      .m_data_i   (m_fwd_data),
      .w_data_i   (w_wd),
      .value_o    (val_a),
      .stall_req_o(stall_a)
   );

   bypass_mux #(.DATA_W(DATA_W), .REG_W(REG_W), .FWD_EN(FWD_EN)) u_mux_b (
      .src_i      (d_rt),
      .use_i      (d_use_rt),
      .t_e_i      (t_e_q),
      .t_m_i      (t_m_q),
      .t_w_i      (t_w_q),
      .rf_data_i  (rd2),
      .e_data_i   (e_fwd_data),
      .m_data_i   (m_fwd_data),
      .w_data_i   (w_wd),
      .value_o    (val_b),
      .stall_req_o(stall_b)
   );

   assign stall   = stall_a | stall_b;
   assign d_ready = ~stall;
   assign issue   = d_valid & ~stall;
   assign load    = issue & ~flush;

   always_comb begin
      t_e_d = '0;
      if (load) begin
         t_e_d.v   = d_we & (d_rd != '0);
         t_e_d.rg  = CPU_REG_W'(d_rd);
         t_e_d.lat = lat_e'(d_lat);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         t_e_q      <= '0;
         t_m_q      <= '0;
         t_w_q      <= '0;
         op_valid_q <= 1'b0;
         op_a_q     <= '0;
         op_b_q     <= '0;
         op_we_q    <= 1'b0;
         op_rd_q    <= '0;
         op_lat_q   <= '0;
      end else begin
         t_w_q      <= t_m_q;
         t_m_q      <= t_e_q;
         t_e_q      <= t_e_d;
         op_valid_q <= load;
         if (load) begin
            op_a_q   <= val_a;
            op_b_q   <= val_b;
            op_we_q  <= d_we;
            op_rd_q  <= d_rd;
            op_lat_q <= d_lat;
         end
      end
   end

   assign op_valid = op_valid_q;
   assign op_a     = op_a_q;
   assign op_b     = op_b_q;
   assign op_we    = op_we_q;
   assign op_rd    = op_rd_q;
   assign op_lat   = op_lat_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: vector table, directed hazard sequences
// and randomized traffic against an age-indexed in-flight writer model.
module tb_operand_fetch;

   localparam bit         FWD    = 1'b1;
   localparam logic [1:0] L_ALU  = 2'd0;
   localparam logic [1:0] L_LOAD = 2'd1;

   logic        clk = 1'b0;
   logic        reset;
   logic        d_valid, d_use_rs, d_use_rt, d_we, d_ready, flush, w_we;
   logic [4:0]  d_rs, d_rt, d_rd, a1, a2, w_a3, op_rd;
   logic [1:0]  d_lat, op_lat;
   logic [31:0] rd1, rd2, e_fwd_data, m_fwd_data, w_wd, op_a, op_b;
   logic        op_valid, op_we;

   always #5 clk = ~clk;

   operand_fetch #(.DATA_W(32), .REG_W(5), .FWD_EN(FWD)) dut (
      .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
      .d_use_rs(d_use_rs), .d_use_rt(d_use_rt), .d_we(d_we), .d_rd(d_rd), .d_lat(d_lat),
      .d_ready(d_ready), .a1(a1), .a2(a2), .rd1(rd1), .rd2(rd2),
      .e_fwd_data(e_fwd_data), .m_fwd_data(m_fwd_data), .w_we(w_we), .w_a3(w_a3),
      .w_wd(w_wd), .flush(flush), .op_valid(op_valid), .op_a(op_a), .op_b(op_b),
      .op_we(op_we), .op_rd(op_rd), .op_lat(op_lat)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   // hist[k]: writer issued k+1 edges ago (k=0 in E, 1 in M, 2 in W)
   typedef struct { bit v; bit [4:0] rg; bit [1:0] lat; } mslot_t;
   mslot_t      hist[3];
   bit          ex_valid, ex_we;
   bit [31:0]   ex_a, ex_b;
   bit [4:0]    ex_rd;
   bit [1:0]    ex_lat;
   logic        seen_ready;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic mreset();
      for (int k = 0; k < 3; k++) begin
         hist[k].v = 1'b0; hist[k].rg = '0; hist[k].lat = '0;
      end
      ex_valid = 0; ex_we = 0; ex_a = '0; ex_b = '0; ex_rd = '0; ex_lat = '0;
   endtask

   // A value is available once its writer reaches W; ALU results earlier via bypass.
   function automatic void operand(input bit [4:0] src, input bit use_src, input bit [31:0] rf,
                                   output bit [31:0] val, output bit stl);
      val = rf;
      stl = 1'b0;
      if (src == 0) begin
         val = '0;
         return;
      end
      if (!use_src) return;
      for (int k = 0; k < 3; k++) begin
         if (hist[k].v && hist[k].rg == src) begin
            if (k == 2)                             val = w_wd;
            else if (FWD && hist[k].lat == L_ALU)   val = (k == 0) ? e_fwd_data : m_fwd_data;
            else                                    stl = 1'b1;
            return;
         end
      end
   endfunction

   task automatic drive(input bit v, input bit [4:0] rs, input bit [4:0] rt, input bit urs,
                        input bit urt, input bit we, input bit [4:0] rd, input bit [1:0] lat);
      d_valid = v; d_rs = rs; d_rt = rt; d_use_rs = urs; d_use_rt = urt;
      d_we = we; d_rd = rd; d_lat = lat; flush = 1'b0;
   endtask

   // Called at posedge+1 with inputs set; returns at the following posedge+1.
   task automatic cycle(input string tag);
      bit [31:0] va, vb;
      bit        sa, sb, stl, ld;
      w_we = hist[2].v;
      w_a3 = hist[2].rg;
      #1;
      operand(d_rs, d_use_rs, rd1, va, sa);
      operand(d_rt, d_use_rt, rd2, vb, sb);
      stl = sa | sb;
      seen_ready = d_ready;
      chk({tag, ".d_ready"}, 32'(d_ready), 32'(!stl));
      chk({tag, ".a1"}, 32'(a1), 32'(d_rs));
      chk({tag, ".a2"}, 32'(a2), 32'(d_rt));
      ld = d_valid && !stl && !flush;
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0].v   = ld && d_we && (d_rd != 0);
      hist[0].rg  = ld ? d_rd : 5'd0;
      hist[0].lat = ld ? d_lat : 2'd0;
      ex_valid = ld;
      if (ld) begin
         ex_a = va; ex_b = vb; ex_we = d_we; ex_rd = d_rd; ex_lat = d_lat;
      end
      @(posedge clk);
      #1;
      chk({tag, ".op_valid"}, 32'(op_valid), 32'(ex_valid));
      chk({tag, ".op_a"}, op_a, ex_a);
      chk({tag, ".op_b"}, op_b, ex_b);
      chk({tag, ".op_we"}, 32'(op_we), 32'(ex_we));
      chk({tag, ".op_rd"}, 32'(op_rd), 32'(ex_rd));
      chk({tag, ".op_lat"}, 32'(op_lat), 32'(ex_lat));
   endtask

   typedef struct {
      bit [4:0]  rs, rt;
      bit        urs, urt;
      bit [31:0] r1, r2, ea, eb;
   } vec_t;
   vec_t tbl[6];

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int stalls;
      reset = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, L_ALU);
      rd1 = '0; rd2 = '0; e_fwd_data = '0; m_fwd_data = '0; w_wd = '0; w_we = 0; w_a3 = '0;
      mreset();
      #2;
      chk("rst.op_valid", 32'(op_valid), 32'd0);
      chk("rst.op_a", op_a, 32'd0);
      chk("rst.op_rd", 32'(op_rd), 32'd0);
      chk("rst.d_ready", 32'(d_ready), 32'd1);
      #10 reset = 1'b1;
      @(posedge clk); #1;

      // Vector table: empty tracker, non-writing instructions
      tbl[0] = '{5'd1,  5'd2,  1, 1, 32'hA1, 32'hB2, 32'hA1, 32'hB2};
      tbl[1] = '{5'd0,  5'd2,  1, 1, 32'hA1, 32'hB2, 32'h0,  32'hB2};
      tbl[2] = '{5'd3,  5'd0,  1, 1, 32'hA1, 32'hB2, 32'hA1, 32'h0};
      tbl[3] = '{5'd0,  5'd0,  0, 0, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0};
      tbl[4] = '{5'd31, 5'd31, 0, 0, 32'h1234_5678, 32'h8765_4321, 32'h1234_5678, 32'h8765_4321};
      tbl[5] = '{5'd5,  5'd9,  1, 0, 32'hDEAD_0000, 32'h0000_BEEF, 32'hDEAD_0000, 32'h0000_BEEF};
      for (int i = 0; i < 6; i++) begin
         drive(1, tbl[i].rs, tbl[i].rt, tbl[i].urs, tbl[i].urt, 0, 5'd9, L_ALU);
         rd1 = tbl[i].r1; rd2 = tbl[i].r2;
         cycle($sformatf("tbl%0d", i));
         chk($sformatf("tbl%0d.a", i), op_a, tbl[i].ea);
         chk($sformatf("tbl%0d.b", i), op_b, tbl[i].eb);
      end

      // E bypass of back-to-back ALU result
      drive(1, 5'd1, 5'd2, 1, 1, 1, 5'd3, L_ALU);
      cycle("t1w");
      drive(1, 5'd3, 5'd3, 1, 1, 1, 5'd4, L_ALU);
      e_fwd_data = 32'h11; rd1 = 32'h99; rd2 = 32'h98;
      cycle("t1");
      chk("t1.no_stall", 32'(seen_ready), 32'd1);
      chk("t1.op_a", op_a, 32'h11);
      chk("t1.op_b", op_b, 32'h11);

      // Load-use: stalls while the load is in E and in M, then takes w_wd
      drive(1, 5'd1, 5'd2, 1, 1, 1, 5'd5, L_LOAD);
      cycle("t2lw");
      drive(1, 5'd5, 5'd0, 1, 1, 1, 5'd6, L_ALU);
      w_wd = 32'hDEAD; rd1 = 32'h0; e_fwd_data = 32'h55; m_fwd_data = 32'h66;
      stalls = 0;
      for (int i = 0; i < 6; i++) begin
         cycle("t2");
         if (seen_ready) break;
         stalls++;
         chk("t2.bubble", 32'(op_valid), 32'd0);
      end
      chk("t2.stall_cycles", 32'(stalls), 32'd2);
      chk("t2.op_a", op_a, 32'hDEAD);
      chk("t2.op_b", op_b, 32'h0);

      // W bypass over a stale register file read
      drive(1, 5'd1, 5'd2, 1, 1, 1, 5'd7, L_ALU);
      cycle("t3w");
      drive(0, 0, 0, 0, 0, 0, 0, L_ALU);
      cycle("t3i0");
      cycle("t3i1");
      drive(1, 5'd7, 5'd1, 1, 0, 0, 5'd0, L_ALU);
      rd1 = 32'h0; w_wd = 32'hCAFE;
      cycle("t3");
      chk("t3.w_we", 32'(w_we), 32'd1);
      chk("t3.op_a", op_a, 32'hCAFE);

      // $0 destination records nothing, $0 source never stalls
      drive(1, 5'd1, 5'd2, 1, 1, 1, 5'd0, L_LOAD);
      cycle("t4w");
      drive(1, 5'd0, 5'd0, 1, 1, 1, 5'd8, L_ALU);
      rd1 = 32'h77; rd2 = 32'h78;
      cycle("t4");
      chk("t4.no_stall", 32'(seen_ready), 32'd1);
      chk("t4.op_a", op_a, 32'h0);

      // Asynchronous reset while a stall is pending
      drive(1, 5'd1, 5'd2, 1, 1, 1, 5'd5, L_LOAD);
      cycle("t5lw");
      drive(1, 5'd5, 5'd5, 1, 1, 1, 5'd6, L_ALU);
      #1;
      chk("t5.stall", 32'(d_ready), 32'd0);
      #2 reset = 1'b0;
      #1;
      chk("t5.d_ready", 32'(d_ready), 32'd1);
      chk("t5.op_valid", 32'(op_valid), 32'd0);
      chk("t5.op_a", op_a, 32'd0);
      mreset();
      d_valid = 1'b0;
      #2 reset = 1'b1;
      @(posedge clk); #1;

      // Flush kills the issuing writer; follower reads the register file
      drive(1, 5'd1, 5'd2, 1, 1, 1, 5'd8, L_ALU);
      flush = 1'b1;
      cycle("t6f");
      chk("t6.flush_valid", 32'(op_valid), 32'd0);
      chk("t6.flush_ready", 32'(seen_ready), 32'd1);
      drive(1, 5'd8, 5'd2, 1, 1, 1, 5'd9, L_ALU);
      rd1 = 32'h1234; e_fwd_data = 32'hBAD0;
      cycle("t6");
      chk("t6.no_stall", 32'(seen_ready), 32'd1);
      chk("t6.op_a", op_a, 32'h1234);

      // Randomized traffic on a small register window to provoke hazards
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 9) < 7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 8, $urandom_range(0, 1) == 1,
               5'($urandom_range(0, 3)), 2'($urandom_range(0, 2)));
         flush = ($urandom_range(0, 9) == 0);
         rd1 = $urandom; rd2 = $urandom;
         e_fwd_data = $urandom; m_fwd_data = $urandom; w_wd = $urandom;
         cycle("rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
